// File: rtl/rt_imp_hls_deadlock_report_unit_pkg.sv
// Shared types and constants for the deadlock report unit:
// FSM state encoding, walk counter width and a constant clog2.
package rt_imp_hls_deadlock_report_unit_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WALK   = 3'd2,
    ST_REPORT = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rt_imp_hls_deadlock_report_unit_if.sv
// Detect/token/report bundle between the process detect units and the
// report unit. slave = report unit side, master = surrounding fabric.
interface rt_imp_hls_deadlock_report_unit_if
  import rt_imp_hls_deadlock_report_unit_pkg::*;
#(
  parameter int PROC_NUM = 4
) ();
  localparam int ID_W = clog2(PROC_NUM);

  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_vec;
  logic                dl_detect;
  logic [PROC_NUM-1:0] origin_vec;
  logic                token_clear;
  logic                rpt_vld;
  logic                rpt_ready;
  logic [ID_W-1:0]     rpt_origin;
  logic [PROC_NUM-1:0] rpt_mask;
  logic                rpt_timeout;

  modport slave (
    input  dl_detect_vec, token_vec, rpt_ready,
    output dl_detect, origin_vec, token_clear,
           rpt_vld, rpt_origin, rpt_mask, rpt_timeout
  );

  modport master (
    output dl_detect_vec, token_vec, rpt_ready,
    input  dl_detect, origin_vec, token_clear,
           rpt_vld, rpt_origin, rpt_mask, rpt_timeout
  );
endinterface

// File: rtl/rt_imp_hls_dl_prio_enc.sv
// Lowest-index-first priority encoder used to pick the walk origin.
module rt_imp_hls_dl_prio_enc #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2
) (
  input  logic [PROC_NUM-1:0] req_i,
  output logic [ID_W-1:0]     idx_o,
  output logic                vld_o
);

  // Scan high to low so the lowest set bit is the last writer.
  always_comb begin
    idx_o = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (req_i[i]) idx_o = ID_W'(i);
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/rt_imp_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process, walks a token around the
// wait-for graph, records which processes it reached and reports once.
module rt_imp_hls_deadlock_report_unit
  import rt_imp_hls_deadlock_report_unit_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int WALK_TIMEOUT = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  rt_imp_hls_deadlock_report_unit_if.slave  bus
);

  localparam int ID_W = clog2(PROC_NUM);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     origin_q, origin_d;
  logic [PROC_NUM-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dl_detect_q, dl_detect_d;
  logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
  logic                rpt_vld_q, rpt_vld_d;
  logic [ID_W-1:0]     rpt_origin_q, rpt_origin_d;
  logic [PROC_NUM-1:0] rpt_mask_q, rpt_mask_d;
  logic                rpt_timeout_q, rpt_timeout_d;
  logic                token_clear;

  logic [ID_W-1:0]     enc_idx;
  logic                enc_vld;
  logic [PROC_NUM-1:0] mask_upd;
  logic                tok_ret;
  logic                tmo_hit;

  rt_imp_hls_dl_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .req_i (bus.dl_detect_vec),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  assign mask_upd = mask_q | bus.token_vec;
  assign tok_ret  = bus.token_vec[origin_q];
  assign tmo_hit  = (cnt_q == CNT_W'(WALK_TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      origin_q      <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      dl_detect_q   <= 1'b0;
      origin_vec_q  <= '0;
      rpt_vld_q     <= 1'b0;
      rpt_origin_q  <= '0;
      rpt_mask_q    <= '0;
      rpt_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      origin_q      <= origin_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      dl_detect_q   <= dl_detect_d;
      origin_vec_q  <= origin_vec_d;
      rpt_vld_q     <= rpt_vld_d;
      rpt_origin_q  <= rpt_origin_d;
      rpt_mask_q    <= rpt_mask_d;
      rpt_timeout_q <= rpt_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    origin_d      = origin_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    dl_detect_d   = dl_detect_q;
    origin_vec_d  = origin_vec_q;
    rpt_vld_d     = rpt_vld_q;
    rpt_origin_d  = rpt_origin_q;
    rpt_mask_d    = rpt_mask_q;
    rpt_timeout_d = rpt_timeout_q;
    token_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          origin_d     = enc_idx;
          mask_d       = '0;
          cnt_d        = '0;
          // Strobe and global flag are registered, so they appear in START.
          origin_vec_d = PROC_NUM'(1) << enc_idx;
          dl_detect_d  = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        mask_d       = mask_q | (PROC_NUM'(1) << origin_q);
        origin_vec_d = '0;
        state_d      = ST_WALK;
      end
      ST_WALK: begin
        mask_d = mask_upd;
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // A returning token wins over a coincident timeout.
        if (tok_ret || tmo_hit) begin
          token_clear   = 1'b1;
          rpt_vld_d     = 1'b1;
          rpt_origin_d  = origin_q;
          rpt_mask_d    = mask_upd;
          rpt_timeout_d = !tok_ret;
          state_d       = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.rpt_ready) begin
          rpt_vld_d     = 1'b0;
          rpt_origin_d  = '0;
          rpt_mask_d    = '0;
          rpt_timeout_d = 1'b0;
          state_d       = ST_HALT;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dl_detect   = dl_detect_q;
  assign bus.origin_vec  = origin_vec_q;
  assign bus.token_clear = token_clear;
  assign bus.rpt_vld     = rpt_vld_q;
  assign bus.rpt_origin  = rpt_origin_q;
  assign bus.rpt_mask    = rpt_mask_q;
  assign bus.rpt_timeout = rpt_timeout_q;

endmodule

// File: tb/tb_rt_imp_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit (PROC_NUM=4, WALK_TIMEOUT=8).
module tb_rt_imp_hls_deadlock_report_unit;
  import rt_imp_hls_deadlock_report_unit_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  rt_imp_hls_deadlock_report_unit_if #(.PROC_NUM(N)) bus ();

  rt_imp_hls_deadlock_report_unit #(
    .PROC_NUM     (N),
    .WALK_TIMEOUT (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {dl_detect, origin_vec, token_clear, rpt_vld, rpt_origin, rpt_mask, rpt_timeout}
  function automatic logic [13:0] obs();
    return {bus.dl_detect, bus.origin_vec, bus.token_clear, bus.rpt_vld,
            bus.rpt_origin, bus.rpt_mask, bus.rpt_timeout};
  endfunction

  function automatic logic [13:0] ex(logic dl, logic [3:0] ov, logic tc, logic vld,
                                     logic [1:0] org, logic [3:0] msk, logic tmo);
    return {dl, ov, tc, vld, org, msk, tmo};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    bus.dl_detect_vec = '0;
    bus.token_vec     = '0;
    bus.rpt_ready     = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    bus.dl_detect_vec = '0;
    bus.token_vec     = '0;
    bus.rpt_ready     = 1'b0;
    #1 reset = 1'b0;
    #1;
    e = '0;
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_outs: got %b want %b", obs(), e); end
    n_tests++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL idle_quiet[%0d]: got %b want %b", i, obs(), e); end
    end
  endtask

  task automatic test_token_return();
    logic [13:0] e;
    do_reset();
    bus.dl_detect_vec = 4'b0110;
    #1;
    e = '0;
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL ret_idle: got %b want %b", obs(), e); end
    tick();                         // START
    bus.dl_detect_vec = 4'b1000;    // must not move the latched origin
    #1;
    e = ex(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL ret_start: got %b want %b", obs(), e); end
    tick();                         // WALK 1
    bus.token_vec = 4'b0100;
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL ret_walk1: got %b want %b", obs(), e); end
    tick();                         // WALK 2
    bus.token_vec = 4'b1000;
    #1;
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL ret_walk2: got %b want %b", obs(), e); end
    tick();                         // WALK 3
    bus.token_vec = 4'b0010;
    #1;
    e = ex(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL ret_walk3_clear: got %b want %b", obs(), e); end
    tick();                         // REPORT
    bus.token_vec = 4'b0000;
    bus.dl_detect_vec = 4'b0000;
  endtask

  task automatic test_report_hold();
    logic [13:0] e;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0);
    bus.rpt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL hold[%0d]: got %b want %b", i, obs(), e); end
      tick();
    end
    bus.rpt_ready = 1'b1;
    #1;
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL hold_hs: got %b want %b", obs(), e); end
    tick();                         // HALT
    bus.rpt_ready = 1'b0;
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL halt_outs: got %b want %b", obs(), e); end
    n_tests++;
    if (dut.state_q !== ST_HALT) begin n_fail++; $display("FAIL halt_state: got %0d want %0d", dut.state_q, ST_HALT); end
    bus.dl_detect_vec = 4'b1111;
    bus.token_vec     = 4'b1111;
    bus.rpt_ready     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL halt_ignore[%0d]: got %b want %b", i, obs(), e); end
    end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    do_reset();
    bus.dl_detect_vec = 4'b0001;
    bus.rpt_ready     = 1'b1;       // ignored until REPORT
    tick();                         // START
    bus.dl_detect_vec = 4'b0000;
    #1;
    e = ex(1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tmo_start: got %b want %b", obs(), e); end
    e = ex(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    for (int w = 1; w <= TMO; w++) begin
      tick();
      #1;
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL tmo_walk%0d: got %b want %b", w, obs(), e); end
    end
    tick();                         // counter == 8
    #1;
    e = ex(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tmo_clear: got %b want %b", obs(), e); end
    tick();                         // REPORT, ready already high
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tmo_report: got %b want %b", obs(), e); end
    tick();                         // HALT
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tmo_halt: got %b want %b", obs(), e); end
    bus.rpt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_walk();
    logic [13:0] e;
    do_reset();
    bus.dl_detect_vec = 4'b0100;
    tick();                         // START
    bus.dl_detect_vec = 4'b0000;
    tick();                         // WALK 1
    bus.token_vec = 4'b0001;
    tick();                         // WALK 2
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL mid_walk: got %b want %b", obs(), e); end
    reset = 1'b0;
    #1;
    e = '0;
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL mid_async: got %b want %b", obs(), e); end
    n_tests++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    tick();
    bus.token_vec     = 4'b0000;
    bus.dl_detect_vec = 4'b1000;
    reset = 1'b1;
    tick();                         // START
    bus.dl_detect_vec = 4'b0000;
    #1;
    e = ex(1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL mid_restart: got %b want %b", obs(), e); end
    tick();                         // WALK 1
    bus.token_vec = 4'b1000;
    #1;
    e = ex(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL mid_clear: got %b want %b", obs(), e); end
    tick();                         // REPORT
    bus.token_vec = 4'b0000;
    #1;
    e = ex(1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL mid_report: got %b want %b", obs(), e); end
  endtask

  task automatic test_return_at_timeout();
    logic [13:0] e;
    int pulses;
    pulses = 0;
    do_reset();
    bus.dl_detect_vec = 4'b0010;
    tick();                         // START
    bus.dl_detect_vec = 4'b0000;
    for (int w = 1; w <= TMO; w++) begin
      tick();
      #1;
      pulses += int'(bus.token_clear);
    end
    tick();                         // counter == 8, token returns
    bus.token_vec = 4'b0010;
    #1;
    pulses += int'(bus.token_clear);
    e = ex(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tie_clear: got %b want %b", obs(), e); end
    tick();                         // REPORT
    bus.token_vec = 4'b0000;
    #1;
    pulses += int'(bus.token_clear);
    e = ex(1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL tie_report: got %b want %b", obs(), e); end
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL tie_pulses: got %0d want 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_token_return();
    test_report_hold();
    test_timeout();
    test_reset_mid_walk();
    test_return_at_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_imp_hls_deadlock_report_unit.md
RT_IMP_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: rt_imp_hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of monitored processes; legal range 2..64.
REQ-002 SHALL have parameter WALK_TIMEOUT, default 255: maximum WALK cycles; legal range 1..255.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clock, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port dl_detect_vec, input, PROC_NUM bits: per-process deadlock detect, bit i from process i's detect unit.
REQ-006 SHALL have port token_vec, input, PROC_NUM bits: bit i = OR of token inputs arriving at process i.
REQ-007 SHALL have port dl_detect, output, 1 bit: global deadlock flag, fanned out to every detect unit's detect input.
REQ-008 SHALL have port origin_vec, output, PROC_NUM bits: one-hot origin strobe to the chosen process.
REQ-009 SHALL have port token_clear, output, 1 bit: broadcast token-kill strobe.
REQ-010 SHALL have port rpt_vld, output, 1 bit: report valid.
REQ-011 SHALL have port rpt_ready, input, 1 bit: report accepted.
REQ-012 SHALL have port rpt_origin, output, ID_W = clog2(PROC_NUM) bits: index of the origin process.
REQ-013 SHALL have port rpt_mask, output, PROC_NUM bits: processes found on the deadlock cycle.
REQ-014 SHALL have port rpt_timeout, output, 1 bit: set when the walk aborted on timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, WALK, REPORT, HALT; reset state IDLE.
REQ-016 IDLE: if |dl_detect_vec, SHALL latch origin = lowest set index, clear mask, load walk counter 0, and go to START next cycle.
REQ-017 IDLE with dl_detect_vec==0: SHALL stay in IDLE with all outputs 0.
REQ-018 START: SHALL drive origin_vec = 1<<origin for exactly one cycle, set mask bit origin, and go to WALK.
REQ-019 dl_detect SHALL be registered, 1 from the first START cycle onward, and sticky until reset.
REQ-020 WALK: each cycle SHALL do mask |= token_vec and counter += 1.
REQ-021 WALK: if token_vec[origin]==1, SHALL pulse token_clear in that same cycle (combinational from state and token_vec) and go to REPORT with rpt_timeout=0.
REQ-022 WALK: if counter==WALK_TIMEOUT and no token returned, SHALL pulse token_clear for one cycle and go to REPORT with rpt_timeout=1.
REQ-023 WALK: a token return coinciding with timeout SHALL take priority as a return, with rpt_timeout=0.
REQ-024 Counter SHALL be 8 bits and saturate; it SHALL never wrap.
REQ-025 REPORT: rpt_vld=1 with rpt_origin, rpt_mask and rpt_timeout held stable until the cycle in which rpt_vld&rpt_ready.
REQ-026 REPORT: on that handshake SHALL move to HALT next cycle with rpt_vld=0.
REQ-027 rpt_ready while not in REPORT SHALL be ignored.
REQ-028 HALT: SHALL ignore all inputs; dl_detect stays 1, all other outputs 0; exit only by reset.
REQ-029 dl_detect_vec changes after IDLE SHALL NOT alter the latched origin.
REQ-030 Outputs origin_vec, rpt_* and dl_detect SHALL be register-driven; token_clear is the only combinational output.

Reset
REQ-031 Reset assertion in any state SHALL force IDLE and clear origin, mask, counter, dl_detect, origin_vec, rpt_vld, rpt_timeout, token_clear=0 within the same cycle (asynchronous).
REQ-032 After reset deassertion, the first transition SHALL be evaluated at the next rising clock.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (3-bit), a clog2 function, and the 8-bit counter width constant.
REQ-034 The lowest-index-first priority encoder SHALL be a sub-module rt_imp_hls_dl_prio_enc (PROC_NUM in, index and any-valid out).
REQ-035 Target size is 150-300 RTL lines.

Verification (PROC_NUM=4, WALK_TIMEOUT=8)
REQ-036 Stimulus: dl_detect_vec=4'b0110; token_vec=4'b0100, then 4'b1000, then 4'b0010 on consecutive WALK cycles. Required: origin_vec=4'b0010 for one cycle; token_clear on the third WALK cycle; rpt_origin=1, rpt_mask=4'b1110, rpt_timeout=0.
REQ-037 Stimulus: dl_detect_vec=4'b0001; token_vec=0 for the whole walk. Required: token_clear after 8 WALK cycles; rpt_timeout=1, rpt_mask=4'b0001.
REQ-038 Stimulus: rpt_ready low for 5 cycles in REPORT, then high. Required: rpt_vld and the payload stable across all 5 cycles; HALT the following cycle; dl_detect stays 1.
REQ-039 Stimulus: reset asserted mid-WALK. Required: all outputs 0 immediately; FSM in IDLE; a new dl_detect_vec=4'b1000 yields rpt_origin=3.
REQ-040 Stimulus: token return on the same cycle the counter reaches 8. Required: rpt_timeout=0; single token_clear pulse.
